// File: rtl/apb_pkg.sv
// Shared types for the APB arbiter: FSM state encoding and watchdog counter width.
package apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_arb_state_t;

  // Wide enough for any TIMEOUT up to 255 ACCESS cycles.
  localparam int WDOG_W = 8;

endpackage : apb_pkg

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after (last_grant+1) mod N wins.
module rr_arbiter #(
  parameter int N_MASTERS = 2,
  parameter int IDX_W     = $clog2(N_MASTERS)
) (
  input  logic [N_MASTERS-1:0] req_i,
  input  logic [IDX_W-1:0]     last_grant_i,
  output logic [IDX_W-1:0]     grant_o,
  output logic                 valid_o
);

  logic [IDX_W-1:0] idx;

  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    grant_o = '0;
    valid_o = 1'b0;
    idx     = '0;
    for (int off = 1; off <= N_MASTERS; off++) begin
      idx = IDX_W'((int'(last_grant_i) + off) % N_MASTERS);
      if (!valid_o && req_i[idx]) begin
        valid_o = 1'b1;
        grant_o = idx;
      end
    end
  end

endmodule : rr_arbiter

// File: rtl/apb_arbiter.sv
// N-to-1 APB arbiter: round-robin grant in IDLE, then a SETUP/ACCESS transfer on the
// downstream port with a watchdog that error-completes a slave that never answers.
module apb_arbiter
  import apb_pkg::*;
#(
  parameter int N_MASTERS      = 2,
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int TIMEOUT        = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [N_MASTERS-1:0]                m_psel_i,
  input  logic [N_MASTERS-1:0]                m_pwrite_i,
  input  logic [N_MASTERS*APB_ADDR_WIDTH-1:0] m_paddr_i,
  input  logic [N_MASTERS*APB_DATA_WIDTH-1:0] m_pwdata_i,
  output logic [N_MASTERS-1:0]                m_pready_o,
  output logic [APB_DATA_WIDTH-1:0]           m_prdata_o,
  output logic                                m_pslverr_o,
  output logic                                s_psel_o,
  output logic                                s_penable_o,
  output logic                                s_pwrite_o,
  output logic [APB_ADDR_WIDTH-1:0]           s_paddr_o,
  output logic [APB_DATA_WIDTH-1:0]           s_pwdata_o,
  input  logic                                s_pready_i,
  input  logic [APB_DATA_WIDTH-1:0]           s_prdata_i,
  input  logic                                s_pslverr_i
);

  localparam int                IDX_W     = $clog2(N_MASTERS);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);

  apb_arb_state_t              state_q;
  logic [IDX_W-1:0]            grant_q;
  logic [IDX_W-1:0]            last_grant_q;
  logic [WDOG_W-1:0]           wdog_q;
  logic                        s_psel_q;
  logic                        s_penable_q;
  logic                        s_pwrite_q;
  logic [APB_ADDR_WIDTH-1:0]   s_paddr_q;
  logic [APB_DATA_WIDTH-1:0]   s_pwdata_q;
  logic [N_MASTERS-1:0]        m_pready_q;
  logic [APB_DATA_WIDTH-1:0]   m_prdata_q;
  logic                        m_pslverr_q;

  logic [IDX_W-1:0] rr_grant_d;
  logic             rr_valid_d;
  logic             wdog_fire;

  rr_arbiter #(
    .N_MASTERS (N_MASTERS),
    .IDX_W     (IDX_W)
  ) u_rr (
    .req_i        (m_psel_i),
    .last_grant_i (last_grant_q),
    .grant_o      (rr_grant_d),
    .valid_o      (rr_valid_d)
  );

  // Fires on the TIMEOUT-th ACCESS cycle without s_pready_i; TIMEOUT=0 disables it.
  assign wdog_fire = (TIMEOUT != 0) && (wdog_q == WDOG_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= IDX_W'(N_MASTERS - 1);
      wdog_q       <= '0;
      s_psel_q     <= 1'b0;
      s_penable_q  <= 1'b0;
      s_pwrite_q   <= 1'b0;
      s_paddr_q    <= '0;
      s_pwdata_q   <= '0;
      m_pready_q   <= '0;
      m_prdata_q   <= '0;
      m_pslverr_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking defaults make the completion outputs one-cycle pulses; a later
      // assignment in the same block overrides them for that edge only.
      m_pready_q  <= '0;
      m_prdata_q  <= '0;
      m_pslverr_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (rr_valid_d) begin
            grant_q    <= rr_grant_d;
            s_pwrite_q <= m_pwrite_i[rr_grant_d];
            s_paddr_q  <= m_paddr_i[int'(rr_grant_d)*APB_ADDR_WIDTH +: APB_ADDR_WIDTH];
            s_pwdata_q <= m_pwdata_i[int'(rr_grant_d)*APB_DATA_WIDTH +: APB_DATA_WIDTH];
            s_psel_q   <= 1'b1;
            state_q    <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          s_penable_q <= 1'b1;
          wdog_q      <= '0;
          state_q     <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (s_pready_i || wdog_fire) begin
            // A real slave response wins over a watchdog firing on the same edge.
            m_pready_q[grant_q] <= 1'b1;
            m_prdata_q          <= s_pready_i ? s_prdata_i : '0;
            m_pslverr_q         <= s_pready_i ? s_pslverr_i : 1'b1;
            s_psel_q            <= 1'b0;
            s_penable_q         <= 1'b0;
            last_grant_q        <= grant_q;
            state_q             <= ST_IDLE;
          end else if (TIMEOUT != 0) begin
            wdog_q <= wdog_q + WDOG_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign m_pready_o  = m_pready_q;
  assign m_prdata_o  = m_prdata_q;
  assign m_pslverr_o = m_pslverr_q;
  assign s_psel_o    = s_psel_q;
  assign s_penable_o = s_penable_q;
  assign s_pwrite_o  = s_pwrite_q;
  assign s_paddr_o   = s_paddr_q;
  assign s_pwdata_o  = s_pwdata_q;

endmodule : apb_arbiter

// File: tb/tb_apb_arbiter.sv
// Directed bench for apb_arbiter (2 masters, TIMEOUT=4); outputs sampled on the falling edge.
module tb_apb_arbiter;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    m_psel, m_pwrite;
  logic [N*AW-1:0] m_paddr;
  logic [N*DW-1:0] m_pwdata;
  logic [N-1:0]    m_pready;
  logic [DW-1:0]   m_prdata;
  logic            m_pslverr;
  logic            s_psel, s_penable, s_pwrite;
  logic [AW-1:0]   s_paddr;
  logic [DW-1:0]   s_pwdata;
  logic            s_pready;
  logic [DW-1:0]   s_prdata;
  logic            s_pslverr;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  apb_arbiter #(
    .N_MASTERS      (N),
    .APB_ADDR_WIDTH (AW),
    .APB_DATA_WIDTH (DW),
    .TIMEOUT        (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .m_psel_i    (m_psel),
    .m_pwrite_i  (m_pwrite),
    .m_paddr_i   (m_paddr),
    .m_pwdata_i  (m_pwdata),
    .m_pready_o  (m_pready),
    .m_prdata_o  (m_prdata),
    .m_pslverr_o (m_pslverr),
    .s_psel_o    (s_psel),
    .s_penable_o (s_penable),
    .s_pwrite_o  (s_pwrite),
    .s_paddr_o   (s_paddr),
    .s_pwdata_o  (s_pwdata),
    .s_pready_i  (s_pready),
    .s_prdata_i  (s_prdata),
    .s_pslverr_i (s_pslverr)
  );

  task automatic nxt(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  // Leaves the bench just after a falling edge with rst released: the next rising edge is cycle 1.
  task automatic do_reset();
    rst = 1'b1;
    m_psel = '0; m_pwrite = '0; m_paddr = '0; m_pwdata = '0;
    s_pready = 1'b0; s_prdata = '0; s_pslverr = 1'b0;
    nxt(2);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    nxt();
    total++; if ({s_psel, s_penable, s_pwrite, m_pslverr, m_pready} !== 5'b0) begin bad++; $display("FAIL reset_ctrl: got %b exp 00000", {s_psel, s_penable, s_pwrite, m_pslverr, m_pready}); end
    total++; if (s_paddr !== 32'h0) begin bad++; $display("FAIL reset_paddr: got %h exp 0", s_paddr); end
    total++; if (s_pwdata !== 32'h0) begin bad++; $display("FAIL reset_pwdata: got %h exp 0", s_pwdata); end
    total++; if (m_prdata !== 32'h0) begin bad++; $display("FAIL reset_prdata: got %h exp 0", m_prdata); end
  endtask

  task automatic test_single_write();
    do_reset();
    m_psel = 2'b10; m_pwrite = 2'b10; m_paddr[AW +: AW] = 32'h10; m_pwdata[DW +: DW] = 32'hA5;
    s_pready = 1'b1;
    nxt();
    total++; if ({s_psel, s_penable} !== 2'b10) begin bad++; $display("FAIL sw_c1_sel_en: got %b exp 10", {s_psel, s_penable}); end
    total++; if (s_paddr !== 32'h10) begin bad++; $display("FAIL sw_c1_paddr: got %h exp 10", s_paddr); end
    total++; if (s_pwrite !== 1'b1) begin bad++; $display("FAIL sw_c1_pwrite: got %b exp 1", s_pwrite); end
    total++; if (s_pwdata !== 32'hA5) begin bad++; $display("FAIL sw_c1_pwdata: got %h exp a5", s_pwdata); end
    nxt();
    total++; if ({s_psel, s_penable} !== 2'b11) begin bad++; $display("FAIL sw_c2_sel_en: got %b exp 11", {s_psel, s_penable}); end
    total++; if (m_pready !== 2'b00) begin bad++; $display("FAIL sw_c2_pready: got %b exp 00", m_pready); end
    nxt();
    total++; if (m_pready !== 2'b10) begin bad++; $display("FAIL sw_c3_pready: got %b exp 10", m_pready); end
    total++; if ({s_psel, s_penable, m_pslverr} !== 3'b000) begin bad++; $display("FAIL sw_c3_idle: got %b exp 000", {s_psel, s_penable, m_pslverr}); end
    m_psel = '0;
    nxt();
    total++; if ({m_pready, s_psel} !== 3'b000) begin bad++; $display("FAIL sw_c4_quiet: got %b exp 000", {m_pready, s_psel}); end
    total++; if (s_paddr !== 32'h10) begin bad++; $display("FAIL sw_c4_paddr_hold: got %h exp 10", s_paddr); end
    s_pready = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp_rdy;
    logic [AW-1:0] exp_addr;
    int w;
    do_reset();
    m_psel = 2'b11; m_pwrite = 2'b01;
    m_paddr = {32'h0000_0200, 32'h0000_0100};
    s_pready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_rdy  = (k % 2 == 0) ? 2'b01 : 2'b10;
      exp_addr = (k % 2 == 0) ? 32'h100 : 32'h200;
      w = 0;
      while (m_pready === 2'b00 && w < 8) begin nxt(); w++; end
      total++; if (m_pready !== exp_rdy) begin bad++; $display("FAIL rr_grant%0d: got %b exp %b", k, m_pready, exp_rdy); end
      total++; if (s_paddr !== exp_addr) begin bad++; $display("FAIL rr_addr%0d: got %h exp %h", k, s_paddr, exp_addr); end
      if (k == 3) m_psel = '0;
      nxt();
    end
    s_pready = 1'b0;
    nxt();
  endtask

  task automatic test_wait_read();
    m_psel = 2'b01; m_pwrite = 2'b00; m_paddr[0 +: AW] = 32'h20;
    s_pready = 1'b0; s_prdata = 32'hDEADBEEF; s_pslverr = 1'b0;
    nxt();
    total++; if ({s_psel, s_pwrite, s_paddr} !== {2'b10, 32'h20}) begin bad++; $display("FAIL rd_setup: got %b/%h exp 10/20", {s_psel, s_pwrite}, s_paddr); end
    nxt(2);
    total++; if ({s_penable, m_pready} !== 3'b100) begin bad++; $display("FAIL rd_wait2: got %b exp 100", {s_penable, m_pready}); end
    total++; if (m_prdata !== 32'h0) begin bad++; $display("FAIL rd_wait_prdata: got %h exp 0", m_prdata); end
    nxt();
    total++; if ({s_penable, m_pready} !== 3'b100) begin bad++; $display("FAIL rd_access3: got %b exp 100", {s_penable, m_pready}); end
    s_pready = 1'b1;
    nxt();
    total++; if (m_pready !== 2'b01) begin bad++; $display("FAIL rd_pready: got %b exp 01", m_pready); end
    total++; if (m_prdata !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_prdata: got %h exp deadbeef", m_prdata); end
    total++; if (m_pslverr !== 1'b0) begin bad++; $display("FAIL rd_pslverr: got %b exp 0", m_pslverr); end
    m_psel = '0; s_pready = 1'b0;
    nxt();
    total++; if ({m_pready, m_prdata} !== 34'h0) begin bad++; $display("FAIL rd_pulse_end: got %b/%h exp 00/0", m_pready, m_prdata); end
  endtask

  task automatic test_timeout();
    m_psel = 2'b10; m_pwrite = 2'b10; m_paddr[AW +: AW] = 32'h30;
    s_pready = 1'b0; s_prdata = 32'h12345678; s_pslverr = 1'b0;
    nxt(5);
    total++; if ({s_psel, s_penable, m_pready} !== 4'b1100) begin bad++; $display("FAIL to_access4: got %b exp 1100", {s_psel, s_penable, m_pready}); end
    nxt();
    total++; if (m_pready !== 2'b10) begin bad++; $display("FAIL to_pready: got %b exp 10", m_pready); end
    total++; if (m_pslverr !== 1'b1) begin bad++; $display("FAIL to_pslverr: got %b exp 1", m_pslverr); end
    total++; if (m_prdata !== 32'h0) begin bad++; $display("FAIL to_prdata: got %h exp 0", m_prdata); end
    total++; if ({s_psel, s_penable} !== 2'b00) begin bad++; $display("FAIL to_drop: got %b exp 00", {s_psel, s_penable}); end
    m_psel = '0;
    nxt();
    total++; if ({m_pready, m_pslverr, s_psel} !== 4'b0000) begin bad++; $display("FAIL to_idle: got %b exp 0000", {m_pready, m_pslverr, s_psel}); end
  endtask

  task automatic test_wdog_precedence();
    m_psel = 2'b01; m_pwrite = 2'b00; m_paddr[0 +: AW] = 32'h40;
    s_pready = 1'b0; s_prdata = 32'hCAFE0001; s_pslverr = 1'b0;
    nxt(5);
    s_pready = 1'b1;
    nxt();
    total++; if ({m_pready, m_pslverr} !== 3'b010) begin bad++; $display("FAIL prec_done: got %b exp 010", {m_pready, m_pslverr}); end
    total++; if (m_prdata !== 32'hCAFE0001) begin bad++; $display("FAIL prec_prdata: got %h exp cafe0001", m_prdata); end
    m_psel = '0; s_pready = 1'b0;
    nxt();
  endtask

  task automatic test_slverr_rotation();
    m_psel = 2'b11; s_pready = 1'b1; s_pslverr = 1'b1; s_prdata = '0;
    nxt(3);
    total++; if ({m_pready, m_pslverr} !== 3'b101) begin bad++; $display("FAIL err_first: got %b exp 101", {m_pready, m_pslverr}); end
    s_pslverr = 1'b0;
    nxt(3);
    total++; if ({m_pready, m_pslverr} !== 3'b010) begin bad++; $display("FAIL err_rotate: got %b exp 010", {m_pready, m_pslverr}); end
    m_psel = '0; s_pready = 1'b0;
    nxt();
  endtask

  task automatic test_reset_mid();
    m_psel = 2'b10; m_pwrite = 2'b10; m_paddr[AW +: AW] = 32'h50; m_pwdata[DW +: DW] = 32'h77;
    s_pready = 1'b0;
    nxt(2);
    total++; if ({s_psel, s_penable} !== 2'b11) begin bad++; $display("FAIL rm_access: got %b exp 11", {s_psel, s_penable}); end
    #3 rst = 1'b1;
    #1;
    total++; if ({s_psel, s_penable, s_pwrite, m_pready, m_pslverr} !== 6'b0) begin bad++; $display("FAIL rm_async_ctrl: got %b exp 000000", {s_psel, s_penable, s_pwrite, m_pready, m_pslverr}); end
    total++; if ({s_paddr, s_pwdata, m_prdata} !== 96'h0) begin bad++; $display("FAIL rm_async_data: got %h/%h/%h exp 0", s_paddr, s_pwdata, m_prdata); end
    m_psel = 2'b11; m_paddr = {32'h0000_0200, 32'h0000_0100}; s_pready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    nxt();
    total++; if (s_paddr !== 32'h100) begin bad++; $display("FAIL rm_first_addr: got %h exp 100", s_paddr); end
    nxt();
    total++; if (m_pready !== 2'b00) begin bad++; $display("FAIL rm_no_stale: got %b exp 00", m_pready); end
    nxt();
    total++; if (m_pready !== 2'b01) begin bad++; $display("FAIL rm_master0_first: got %b exp 01", m_pready); end
    m_psel = '0; s_pready = 1'b0;
    nxt();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_round_robin();
    test_wait_read();
    test_timeout();
    test_wdog_precedence();
    test_slverr_rotation();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got running exp finished");
    $fatal(1, "bench did not finish");
  end

endmodule : tb_apb_arbiter

// File: doc/apb_arbiter.md
APB_ARBITER -- requirements
Module: apb_arbiter

Interface
REQ-001 Parameter N_MASTERS, default 2, number of upstream APB requesters (legal 2..8).
REQ-002 Parameter APB_ADDR_WIDTH, default 32, address width.
REQ-003 Parameter APB_DATA_WIDTH, default 32, data width.
REQ-004 Parameter TIMEOUT, default 16, max ACCESS cycles without PREADY; 0 disables the watchdog.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 m_psel_i  input  N_MASTERS  per-master select (request).
REQ-008 m_pwrite_i  input  N_MASTERS  per-master write flag.
REQ-009 m_paddr_i  input  N_MASTERS*APB_ADDR_WIDTH  packed; master k in slice k.
REQ-010 m_pwdata_i  input  N_MASTERS*APB_DATA_WIDTH  packed write data.
REQ-011 m_pready_o  output  N_MASTERS  per-master completion.
REQ-012 m_prdata_o  output  APB_DATA_WIDTH  read data, shared by all masters.
REQ-013 m_pslverr_o  output  1  error, qualified by the granted master's m_pready_o.
REQ-014 s_psel_o, s_penable_o, s_pwrite_o  output  1 each  downstream APB controls.
REQ-015 s_paddr_o  output  APB_ADDR_WIDTH; s_pwdata_o  output  APB_DATA_WIDTH.
REQ-016 s_pready_i  input  1; s_prdata_i  input  APB_DATA_WIDTH; s_pslverr_i  input  1.

Function
REQ-017 FSM states IDLE, SETUP, ACCESS are the only states.
REQ-018 IDLE: if any m_psel_i set, the arbiter grants one master round-robin, starting at (last_grant+1) mod N_MASTERS, registers its index, pwrite, paddr and pwdata, and moves to SETUP; otherwise it stays in IDLE.
REQ-019 SETUP: s_psel_o=1, s_penable_o=0, registered addr/write/wdata driven; next state ACCESS unconditionally.
REQ-020 ACCESS: s_psel_o=1, s_penable_o=1; the arbiter holds this state until s_pready_i=1 or the watchdog fires.
REQ-021 Completion, in the same cycle s_pready_i=1 in ACCESS: m_pready_o[grant]=1, m_prdata_o=s_prdata_i, m_pslverr_o=s_pslverr_i; last_grant<=grant; next state IDLE.
REQ-022 m_pready_o of non-granted masters is always 0; m_prdata_o=0 and m_pslverr_o=0 whenever no completion occurs.
REQ-023 s_psel_o and s_penable_o are 0 in IDLE; s_paddr_o, s_pwrite_o and s_pwdata_o hold their last registered values.
REQ-024 Minimum latency from m_psel_i assertion (arbiter in IDLE) to m_pready_o is 3 cycles; one IDLE cycle always separates transfers.
REQ-025 Watchdog: the counter clears on entering ACCESS and increments each ACCESS cycle without s_pready_i. When it reaches TIMEOUT, the arbiter completes to the master with m_pready_o=1, m_pslverr_o=1, m_prdata_o=0, drops s_psel_o/s_penable_o and returns to IDLE.
REQ-026 If s_pready_i=1 in the same cycle the watchdog fires, normal completion (REQ-021) takes precedence.
REQ-027 Deassertion of m_psel_i by the granted master mid-transfer is ignored; the transfer completes and its result is discarded.
REQ-028 Arbitration is sampled only in IDLE; requests arriving during SETUP/ACCESS wait; no starvation: each requester waits at most N_MASTERS-1 transfers.

Reset
REQ-029 On rst: state=IDLE, all outputs 0, registered addr/wdata/write=0, watchdog=0, last_grant=N_MASTERS-1 (master 0 wins first contention).
REQ-030 Reset asserted mid-transfer aborts immediately; no m_pready_o pulse is issued for the aborted transfer.

Structure
REQ-031 The state enum (apb_arb_state_t) and the watchdog counter width are defined in shared package apb_pkg.
REQ-032 The round-robin pick is a separate combinational sub-module, rr_arbiter (inputs: request vector, last_grant; output: grant index and valid).

Verification
REQ-033 Single master 1 write addr 0x10 data 0xA5, s_pready_i tied 1 -> s_psel_o rises cycle 1, s_penable_o cycle 2, m_pready_o=2'b10 cycle 3.
REQ-034 Masters 0 and 1 request continuously from reset -> grants alternate 0,1,0,1 across four transfers.
REQ-035 Read, slave inserts 2 wait states, s_prdata_i=0xDEADBEEF -> m_pready_o one cycle only, m_prdata_o=0xDEADBEEF, m_pslverr_o=0.
REQ-036 TIMEOUT=4, s_pready_i held 0 -> after 4 ACCESS cycles m_pslverr_o=1, m_pready_o pulses, FSM returns to IDLE.
REQ-037 rst asserted during ACCESS -> all outputs 0 asynchronously; after release master 0 is granted first.
REQ-038 s_pready_i=1 and s_pslverr_i=1 -> m_pslverr_o=1 with m_pready_o; next grant still rotates.
